// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port arbiter/sequencer for the single-ported 64K x 16 main
// memory. Shares the memory between the instruction-fetch port (f_*) and the
// load/store port (d_*), drives memory mode/address/data_in, captures data_out
// and returns it to the winning port with a one-cycle done pulse.
//
// Optional feature macro: ARB_ROUND_ROBIN_EN
//   defined   -> round-robin arbitration on contention (pointer updates on
//                every grant, reset value "data favoured next")
//   undefined -> fixed priority, the data port wins every contention
//
// Handshake: a requester raises req with its address/data stable and keeps
// them stable until its done pulse. Requests are sampled only while the FSM is
// IDLE. done is high for exactly one cycle, in the IDLE cycle following
// CAPTURE; a req still high in that cycle is taken as a new request, so a
// requester wanting a single access drops req no later than that cycle.
//
// Access timeline for a request sampled in IDLE at cycle N:
//   N+1 ISSUE   : mode/address/data_in driven (a write commits at the end)
//   N+2 CAPTURE : mode stays "read" so data_out is valid; captured at the end
//   N+3 IDLE    : done (and rdata for reads) visible; a new request may be
//                 sampled in this same cycle, giving one access per 3 cycles.
module mem_arbiter (
  input  logic        clk,
  input  logic        reset,
  // fetch port (read only)
  input  logic        f_req,
  input  logic [15:0] f_addr,
  output logic [15:0] f_rdata,
  output logic        f_done,
  // data port (read or write)
  input  logic        d_req,
  input  logic        d_we,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic [15:0] d_rdata,
  output logic        d_done,
  // memory side
  output logic [1:0]  mem_mode,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  // status
  output logic        busy,
  output logic [1:0]  dbg_state
);

  // Memory mode encodings (memory `mode` input).
  localparam logic [1:0] MEM_MODE_IDLE = 2'b00;
  localparam logic [1:0] MEM_MODE_IN   = 2'b01;  // write data_in
  localparam logic [1:0] MEM_MODE_OUT  = 2'b10;  // drive data_out

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;

  // Registered grant: who owns the current access and what it asked for.
  logic        gnt_fetch;
  logic        gnt_we;
  logic [15:0] gnt_addr;
  logic [15:0] gnt_wdata;

  logic        any_req;
  logic        grant_now;
  logic        pick_fetch;

  assign any_req   = f_req | d_req;
  assign grant_now = (state == ST_IDLE) && any_req;

`ifdef ARB_ROUND_ROBIN_EN
  // 1 = the data port wins the next contention.
  logic rr_data_next;

  // Round-robin pointer: after a fetch grant favour data, and vice versa.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_data_next <= 1'b1;
    end else if (grant_now) begin
      rr_data_next <= pick_fetch;
    end
  end

  assign pick_fetch = f_req && (!d_req || !rr_data_next);
`else
  // Fixed priority: fetch is granted only when the data port is not asking.
  assign pick_fetch = f_req && !d_req;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: IDLE waits for a request, then ISSUE -> CAPTURE -> IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    state_nxt = any_req ? ST_ISSUE : ST_IDLE;
      ST_ISSUE:   state_nxt = ST_CAPTURE;
      ST_CAPTURE: state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Output logic: memory mode follows state and the registered access type.
  always_comb begin
    mem_mode = MEM_MODE_IDLE;
    case (state)
      ST_ISSUE:   mem_mode = gnt_we ? MEM_MODE_IN : MEM_MODE_OUT;
      ST_CAPTURE: mem_mode = gnt_we ? MEM_MODE_IDLE : MEM_MODE_OUT;
      default:    mem_mode = MEM_MODE_IDLE;
    endcase
  end

  assign busy      = (state != ST_IDLE);
  assign dbg_state = state;
  assign mem_addr  = gnt_addr;
  assign mem_wdata = gnt_wdata;

  // Grant capture: latch the winner's request when leaving IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      gnt_fetch <= 1'b0;
      gnt_we    <= 1'b0;
      gnt_addr  <= 16'h0000;
      gnt_wdata <= 16'h0000;
    end else if (grant_now) begin
      gnt_fetch <= pick_fetch;
      gnt_we    <= pick_fetch ? 1'b0 : d_we;
      gnt_addr  <= pick_fetch ? f_addr : d_addr;
      gnt_wdata <= pick_fetch ? 16'h0000 : d_wdata;
    end
  end

  // Completion: at the end of CAPTURE pulse the owner's done and, for reads,
  // load the owner's rdata; the other port's outputs are left alone.
  always_ff @(posedge clk) begin
    if (reset) begin
      f_done  <= 1'b0;
      d_done  <= 1'b0;
      f_rdata <= 16'h0000;
      d_rdata <= 16'h0000;
    end else begin
      f_done <= (state == ST_CAPTURE) &&  gnt_fetch;
      d_done <= (state == ST_CAPTURE) && !gnt_fetch;
      if ((state == ST_CAPTURE) && !gnt_we) begin
        if (gnt_fetch) begin
          f_rdata <= mem_rdata;
        end else begin
          d_rdata <= mem_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: self-checking bench for mem_arbiter. A simple memory array
// stands in for the main memory; the reference model tracks expected memory
// contents, expected rdata per port and which port was granted last, and
// predicts done timing from the 3-cycle access rule.
`timescale 1ns/1ps
module tb_mem_arbiter;

  localparam logic [1:0] MODE_IDLE = 2'b00;
  localparam logic [1:0] MODE_WR   = 2'b01;
  localparam logic [1:0] MODE_RD   = 2'b10;

  logic        clk;
  logic        reset;
  logic        f_req;
  logic [15:0] f_addr;
  logic [15:0] f_rdata;
  logic        f_done;
  logic        d_req;
  logic        d_we;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic [15:0] d_rdata;
  logic        d_done;
  logic [1:0]  mem_mode;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        busy;
  logic [1:0]  dbg_state;

  mem_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .f_req     (f_req),
    .f_addr    (f_addr),
    .f_rdata   (f_rdata),
    .f_done    (f_done),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_done    (d_done),
    .mem_mode  (mem_mode),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- memory stand-in ----------------
  logic [15:0] mem_array [0:65535];
  always @(posedge clk) begin
    if (mem_mode == MODE_WR) mem_array[mem_addr] <= mem_wdata;
  end
  assign mem_rdata = (mem_mode == MODE_RD) ? mem_array[mem_addr] : 16'h0000;

  // ---------------- reference model / scoreboard ----------------
  logic [15:0] ref_mem [logic [15:0]];
  logic [15:0] exp_q [$];
  logic [15:0] exp_f_rdata;
  logic [15:0] exp_d_rdata;
  bit          last_was_fetch;
  int          n_checks;
  int          n_pass;

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    f_req = 1'b0; f_addr = 16'h0000;
    d_req = 1'b0; d_we = 1'b0; d_addr = 16'h0000; d_wdata = 16'h0000;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if ({mem_mode, f_done, d_done, busy, f_rdata, d_rdata, mem_addr, mem_wdata, dbg_state} !== '0)
        $display("FAIL reset_idle cyc%0d: mode=%0h fd=%0b dd=%0b busy=%0b fr=%h dr=%h ma=%h mw=%h st=%0d want all 0",
                 i, mem_mode, f_done, d_done, busy, f_rdata, d_rdata, mem_addr, mem_wdata, dbg_state);
      else n_pass++;
    end
    last_was_fetch = 1'b1;  // reset state: data favoured next
    exp_f_rdata = 16'h0000;
    exp_d_rdata = 16'h0000;
  endtask

  // One access on one port; checks ISSUE/CAPTURE drive, done latency, owner
  // selection and both ports' rdata against the model.
  task automatic do_access(input bit is_fetch, input bit we, input logic [15:0] addr,
                           input logic [15:0] wdata, input string tag);
    bit          wr;
    bit          seen;
    logic [15:0] exp_data;
    wr   = !is_fetch && we;
    seen = 1'b0;
    if (!wr) exp_q.push_back(ref_mem[addr]);
    else ref_mem[addr] = wdata;
    if (is_fetch) begin
      f_req = 1'b1; f_addr = addr;
    end else begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
    end
    for (int k = 1; k <= 8 && !seen; k++) begin
      @(posedge clk); #1;
      if (f_done || d_done) begin
        seen = 1'b1;
        f_req = 1'b0; d_req = 1'b0;
        n_checks++;
        if (k != 3) $display("FAIL %s_latency: done after %0d cycles, want 3", tag, k);
        else n_pass++;
        n_checks++;
        if ({f_done, d_done} !== {is_fetch, !is_fetch})
          $display("FAIL %s_owner: f_done=%0b d_done=%0b want %0b %0b", tag, f_done, d_done, is_fetch, !is_fetch);
        else n_pass++;
        if (!wr) begin
          exp_data = exp_q.pop_front();
          if (is_fetch) exp_f_rdata = exp_data;
          else exp_d_rdata = exp_data;
        end
        n_checks++;
        if ({f_rdata, d_rdata} !== {exp_f_rdata, exp_d_rdata})
          $display("FAIL %s_rdata: f_rdata=%h d_rdata=%h want %h %h", tag, f_rdata, d_rdata, exp_f_rdata, exp_d_rdata);
        else n_pass++;
        last_was_fetch = is_fetch;
      end else if (k == 1) begin
        n_checks++;
        if (mem_mode !== (wr ? MODE_WR : MODE_RD) || mem_addr !== addr || (wr && mem_wdata !== wdata) || busy !== 1'b1)
          $display("FAIL %s_issue: mode=%0h addr=%h wdata=%h busy=%0b want mode=%0h addr=%h wdata=%h busy=1",
                   tag, mem_mode, mem_addr, mem_wdata, busy, wr ? MODE_WR : MODE_RD, addr, wdata);
        else n_pass++;
      end else if (k == 2) begin
        n_checks++;
        if (mem_mode !== (wr ? MODE_IDLE : MODE_RD))
          $display("FAIL %s_capture_mode: mode=%0h want %0h", tag, mem_mode, wr ? MODE_IDLE : MODE_RD);
        else n_pass++;
      end
    end
    if (!seen) begin
      n_checks++;
      $display("FAIL %s_timeout: no done within 8 cycles, want done at 3", tag);
      f_req = 1'b0; d_req = 1'b0;
      if (!wr) void'(exp_q.pop_front());
    end
    @(posedge clk); #1;
    n_checks++;
    if ({f_done, d_done, busy} !== 3'b000)
      $display("FAIL %s_single_pulse: f_done=%0b d_done=%0b busy=%0b want 0 0 0", tag, f_done, d_done, busy);
    else n_pass++;
  endtask

  task automatic test_write_then_fetch();
    do_access(1'b0, 1'b1, 16'h0010, 16'hBEEF, "wr_0010");
    do_access(1'b1, 1'b0, 16'h0010, 16'h0000, "fetch_0010");
  endtask

  task automatic test_data_read();
    do_access(1'b0, 1'b0, 16'h0010, 16'h0000, "dread_0010");
  endtask

  task automatic test_boundary();
    logic [15:0] v0;
    v0 = 16'($urandom_range(1, 16'hFFFF));
    do_access(1'b0, 1'b1, 16'h0000, v0, "wr_0000");
    do_access(1'b0, 1'b1, 16'hFFFF, 16'h1234, "wr_ffff");
    do_access(1'b0, 1'b0, 16'hFFFF, 16'h0000, "rd_ffff");
    do_access(1'b1, 1'b0, 16'h0000, 16'h0000, "fetch_0000");
  endtask

  task automatic test_random();
    logic [15:0] pool [8];
    bit          is_f;
    bit          we;
    for (int i = 0; i < 4; i++) begin
      pool[i]     = 16'h0100 + 16'(i);
      pool[i + 4] = 16'hFFF0 + 16'(i);
    end
    for (int i = 0; i < 8; i++) do_access(1'b0, 1'b1, pool[i], 16'($urandom), "rnd_init");
    for (int i = 0; i < 24; i++) begin
      is_f = 1'($urandom_range(0, 1));
      we   = is_f ? 1'b0 : 1'($urandom_range(0, 1));
      do_access(is_f, we, pool[$urandom_range(0, 7)], 16'($urandom), "rnd");
    end
  endtask

  // Both ports held for 12 cycles; done pulses every third cycle, winner
  // from the arbitration rule applied to the model's last grant.
  task automatic test_contention(input string tag);
    logic [15:0] fa;
    logic [15:0] da;
    bit          exp_fetch;
    fa = 16'h0010;
    da = 16'hFFFF;
    f_req = 1'b1; f_addr = fa;
    d_req = 1'b1; d_we = 1'b0; d_addr = da; d_wdata = 16'h0000;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      if (k % 3 == 0) begin
`ifdef ARB_ROUND_ROBIN_EN
        exp_fetch = !last_was_fetch;
`else
        exp_fetch = 1'b0;
`endif
        if (exp_fetch) exp_f_rdata = ref_mem[fa];
        else exp_d_rdata = ref_mem[da];
        last_was_fetch = exp_fetch;
        n_checks++;
        if ({f_done, d_done} !== {exp_fetch, !exp_fetch} || f_rdata !== exp_f_rdata || d_rdata !== exp_d_rdata)
          $display("FAIL %s_pulse k=%0d: fd=%0b dd=%0b fr=%h dr=%h want %0b %0b %h %h",
                   tag, k, f_done, d_done, f_rdata, d_rdata, exp_fetch, !exp_fetch, exp_f_rdata, exp_d_rdata);
        else n_pass++;
      end else begin
        n_checks++;
        if ({f_done, d_done} !== 2'b00)
          $display("FAIL %s_quiet k=%0d: fd=%0b dd=%0b want 0 0", tag, k, f_done, d_done);
        else n_pass++;
      end
      if (k == 12) begin
        f_req = 1'b0; d_req = 1'b0;
      end
    end
    @(posedge clk); #1;
    n_checks++;
    if ({f_done, d_done, busy} !== 3'b000)
      $display("FAIL %s_drain: fd=%0b dd=%0b busy=%0b want 0 0 0", tag, f_done, d_done, busy);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    f_req = 1'b1; f_addr = 16'h0010;
    @(posedge clk); #1;
    n_checks++;
    if (busy !== 1'b1 || mem_mode !== MODE_RD)
      $display("FAIL rstmid_issue: busy=%0b mode=%0h want 1 %0h", busy, mem_mode, MODE_RD);
    else n_pass++;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    f_req = 1'b0;
    n_checks++;
    if ({mem_mode, f_done, d_done, busy, f_rdata, d_rdata, mem_addr, mem_wdata, dbg_state} !== '0)
      $display("FAIL rstmid_outputs: mode=%0h fd=%0b dd=%0b busy=%0b fr=%h dr=%h ma=%h mw=%h st=%0d want all 0",
               mem_mode, f_done, d_done, busy, f_rdata, d_rdata, mem_addr, mem_wdata, dbg_state);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if ({f_done, d_done, busy} !== 3'b000)
        $display("FAIL rstmid_no_done cyc%0d: fd=%0b dd=%0b busy=%0b want 0 0 0", i, f_done, d_done, busy);
      else n_pass++;
    end
    last_was_fetch = 1'b1;
    exp_f_rdata = 16'h0000;
    exp_d_rdata = 16'h0000;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_checks = 0;
    n_pass   = 0;
    test_reset();
    test_write_then_fetch();
    test_data_read();
    test_boundary();
    test_random();
    test_contention("cont1");
    test_reset_mid();
    test_contention("cont_after_rst");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, want completion");
    $fatal(1);
  end

endmodule
